mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, data width of the data memory and both requester ports.
REQ-002 Parameter: ADDR_W, 8, data-memory address width.
REQ-003 Parameter: STARVE_MAX, 4, consecutive CPU wins tolerated while the device waits (range 1-15).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: cpu_read  in  1  CPU load request (control-unit read).
REQ-007 Port: cpu_write  in  1  CPU store request (control-unit write).
REQ-008 Port: cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and store data.
REQ-009 Port: cpu_rdata  out  DATA_W  CPU load data.
REQ-010 Port: cpu_stall  out  1  hold PC and CPU state this cycle (drives enable_pc low externally).
REQ-011 Port: dev_req / dev_we  in  1 / 1  I/O device access request and write select.
REQ-012 Port: dev_addr / dev_wdata  in  ADDR_W / DATA_W  device address and write data.
REQ-013 Port: dev_gnt  out  1  one-cycle pulse; device access issued this cycle.
REQ-014 Port: dev_rdata / dev_rvalid  out  DATA_W / 1  device read data and its one-cycle valid.
REQ-015 Port: mem_en / mem_we  out  1 / 1  synchronous single-port RAM enable and write enable.
REQ-016 Port: mem_addr / mem_wdata  out  ADDR_W / DATA_W  RAM address and write data.
REQ-017 Port: mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read issue.

Function
REQ-018 FSM states SHALL be IDLE, CPU_RD_WAIT, DEV_RD_WAIT; no other states.
REQ-019 CPU request = cpu_read | cpu_write; cpu_read and cpu_write both high SHALL be handled as a write.
REQ-020 In IDLE the winner SHALL be: device if dev_req and CPU request and starve_cnt == STARVE_MAX; else CPU if CPU request; else device if dev_req; else none.
REQ-021 Only one RAM access SHALL be issued per cycle, and only from IDLE; wait states issue nothing (mem_en=0).
REQ-022 CPU write win: mem_en=1, mem_we=1, cpu_addr/cpu_wdata driven, cpu_stall=0 same cycle, stay IDLE.
REQ-023 CPU read win: mem_en=1, mem_we=0, cpu_stall=1, next state CPU_RD_WAIT.
REQ-024 CPU_RD_WAIT: cpu_rdata=mem_rdata, cpu_stall=0, next state IDLE; CPU read latency is exactly 2 cycles.
REQ-025 Device win: dev_gnt=1, mem_en=1, mem_we=dev_we, dev_addr/dev_wdata driven; write stays IDLE, read goes to DEV_RD_WAIT.
REQ-026 DEV_RD_WAIT: dev_rvalid=1, dev_rdata=mem_rdata, next state IDLE.
REQ-027 cpu_stall SHALL be 1 whenever a CPU request is present and not served this cycle (device wins, or state is DEV_RD_WAIT), and in the CPU read issue cycle.
REQ-028 cpu_stall SHALL be 0 with no CPU request; cpu_rdata and dev_rdata SHALL be 0 outside their valid cycles.
REQ-029 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, on each CPU win with dev_req=1, and clear on a device win or any cycle with dev_req=0.
REQ-030 dev_req SHALL be held by the device until dev_gnt; request fields SHALL be sampled only in the dev_gnt cycle.
REQ-031 mem_addr/mem_wdata SHALL be 0 when mem_en=0.
REQ-032 All mem_*, cpu_stall, dev_gnt, and read-data outputs SHALL be combinational from state and inputs; state and starve_cnt are the only registers.

Reset
REQ-033 reset SHALL immediately force IDLE and starve_cnt=0; dev_rvalid=0, dev_gnt=0, mem_en=0, cpu_stall reflects only current inputs.
REQ-034 Reset asserted in a wait state SHALL discard the pending read; no dev_rvalid or CPU read completion follows.

Verification
REQ-035 CPU store addr 0x10 data 0x5A, no device -> same cycle mem_en=1, mem_we=1, cpu_stall=0; later CPU load 0x10 -> stall 1 cycle, cpu_rdata=0x5A next cycle.
REQ-036 Device write 0x20=0x33 in idle -> dev_gnt same cycle; device read 0x20 -> dev_rvalid=1, dev_rdata=0x33 one cycle after dev_gnt.
REQ-037 CPU stores every cycle, dev_req held, STARVE_MAX=4 -> 4 CPU wins, device wins 5th cycle with cpu_stall=1, then CPU resumes.
REQ-038 CPU load issued while device read in DEV_RD_WAIT -> cpu_stall=1 that cycle, CPU load issued next cycle.
REQ-039 Reset pulsed during CPU_RD_WAIT -> state IDLE, cpu_stall=0 with no request, no data delivered.
REQ-040 cpu_read=cpu_write=1, addr 0x05 data 0x7F -> treated as write, mem_we=1, no stall; read back 0x05 returns 0x7F.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port data RAM between the CPU
// load/store path and an I/O device. The CPU normally has priority, but the
// device is guaranteed a slot after STARVE_MAX consecutive CPU wins while it
// waits. All datapath/handshake outputs are combinational from the current
// state and inputs; only the FSM state and the starvation counter are stored.
module mem_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    // CPU (control unit) side
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    // I/O device side
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic              dev_gnt,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              dev_rvalid,

    // Synchronous single-port RAM
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CPU_RD_WAIT = 2'd1,
        DEV_RD_WAIT = 2'd2
    } state_t;

    // Counter limit narrowed to the 4-bit counter width.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    logic cpu_req;
    logic dev_win;
    logic cpu_win;

    // Arbitration decision for the current IDLE cycle; a simultaneous read and
    // write from the CPU counts as a single write request.
    always_comb begin
        cpu_req = cpu_read | cpu_write;
        dev_win = 1'b0;
        cpu_win = 1'b0;
        if (!reset && state_q == IDLE) begin
            dev_win = dev_req && (!cpu_req || starve_q == STARVE_LIM);
            cpu_win = cpu_req && !dev_win;
        end
    end

    // Next-state and output decode; the RAM is only ever driven from IDLE.
    always_comb begin
        state_d    = state_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        dev_gnt    = 1'b0;
        dev_rdata  = '0;
        dev_rvalid = 1'b0;

        if (reset) begin
            // Nothing is issued while held in reset; the CPU is simply told
            // that any request it presents is not being served.
            cpu_stall = cpu_req;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dev_win) begin
                        dev_gnt   = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = dev_we;
                        mem_addr  = dev_addr;
                        mem_wdata = dev_wdata;
                        cpu_stall = cpu_req;
                        if (!dev_we) begin
                            state_d = DEV_RD_WAIT;
                        end
                    end else if (cpu_win) begin
                        mem_en   = 1'b1;
                        mem_addr = cpu_addr;
                        if (cpu_write) begin
                            mem_we    = 1'b1;
                            mem_wdata = cpu_wdata;
                        end else begin
                            cpu_stall = 1'b1;
                            state_d   = CPU_RD_WAIT;
                        end
                    end
                end

                CPU_RD_WAIT: begin
                    cpu_rdata = mem_rdata;
                    state_d   = IDLE;
                end

                DEV_RD_WAIT: begin
                    dev_rvalid = 1'b1;
                    dev_rdata  = mem_rdata;
                    cpu_stall  = cpu_req;
                    state_d    = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts CPU wins while the device is waiting and is
    // cleared as soon as the device is served or stops asking.
    always_comb begin
        starve_d = starve_q;
        if (dev_win || !dev_req) begin
            starve_d = 4'd0;
        end else if (cpu_win && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State registers; reset drops any read that was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// synchronous RAM and read-data scoreboards for the CPU and device ports.
module tb_mem_arbiter;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_read, cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              dev_req, dev_we;
    logic [ADDR_W-1:0] dev_addr;
    logic [DATA_W-1:0] dev_wdata, dev_rdata;
    logic              dev_gnt, dev_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] cpu_q[$];
    logic [DATA_W-1:0] dev_q[$];
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dev_req(dev_req), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_gnt(dev_gnt), .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural synchronous RAM: read data appears the cycle after issue.
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_read  = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dev_req   = 1'b0; dev_we    = 1'b0; dev_addr = '0; dev_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        cycle();
        #2;
        checks++; if (mem_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_en: got %b expected 0", mem_en); end
        checks++; if (dev_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rst_dev_gnt: got %b expected 0", dev_gnt); end
        checks++; if (dev_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_dev_rvalid: got %b expected 0", dev_rvalid); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_cpu_stall: got %b expected 0", cpu_stall); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL rst_mem_addr: got %h expected 00", mem_addr); end
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_cpu_write_read();
        logic [DATA_W-1:0] exp;
        idle_inputs();
        cpu_write = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
        #2;
        checks++; if (mem_en !== 1'b1) begin failures++; $display("[TB] FAIL cpuwr_en: got %b expected 1", mem_en); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL cpuwr_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 8'h10) begin failures++; $display("[TB] FAIL cpuwr_addr: got %h expected 10", mem_addr); end
        checks++; if (mem_wdata !== 8'h5A) begin failures++; $display("[TB] FAIL cpuwr_wdata: got %h expected 5a", mem_wdata); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL cpuwr_stall: got %b expected 0", cpu_stall); end
        cycle();
        idle_inputs();
        #2;
        checks++; if (mem_en !== 1'b0 || mem_wdata !== 8'h00) begin failures++; $display("[TB] FAIL idle_mem: got en=%b wdata=%h expected en=0 wdata=00", mem_en, mem_wdata); end
        cycle();
        cpu_read = 1'b1; cpu_addr = 8'h10;
        #2;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("[TB] FAIL cpurd_issue_stall: got %b expected 1", cpu_stall); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin failures++; $display("[TB] FAIL cpurd_issue_mem: got en=%b we=%b addr=%h expected en=1 we=0 addr=10", mem_en, mem_we, mem_addr); end
        cpu_q.push_back(8'h5A);
        cycle();
        #2;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL cpurd_wait_stall: got %b expected 0", cpu_stall); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("[TB] FAIL cpurd_wait_en: got %b expected 0", mem_en); end
        if (cpu_q.size() == 0) begin
            checks++; failures++; $display("[TB] FAIL cpurd_sb: got empty queue expected entry");
        end else begin
            exp = cpu_q.pop_front();
            checks++; if (cpu_rdata !== exp) begin failures++; $display("[TB] FAIL cpurd_data: got %h expected %h", cpu_rdata, exp); end
        end
        cycle();
        idle_inputs();
        #2;
        checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("[TB] FAIL cpurd_after: got %h expected 00", cpu_rdata); end
        cycle();
    endtask

    task automatic test_dev_write_read();
        logic [DATA_W-1:0] exp;
        idle_inputs();
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = 8'h20; dev_wdata = 8'h33;
        #2;
        checks++; if (dev_gnt !== 1'b1) begin failures++; $display("[TB] FAIL devwr_gnt: got %b expected 1", dev_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h33) begin failures++; $display("[TB] FAIL devwr_mem: got en=%b we=%b addr=%h wdata=%h expected 1 1 20 33", mem_en, mem_we, mem_addr, mem_wdata); end
        cycle();
        idle_inputs();
        #2;
        checks++; if (dev_gnt !== 1'b0 || dev_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL devwr_after: got gnt=%b rvalid=%b expected 0 0", dev_gnt, dev_rvalid); end
        cycle();
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = 8'h20;
        #2;
        checks++; if (dev_gnt !== 1'b1 || mem_we !== 1'b0 || dev_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL devrd_issue: got gnt=%b we=%b rvalid=%b expected 1 0 0", dev_gnt, mem_we, dev_rvalid); end
        dev_q.push_back(8'h33);
        cycle();
        idle_inputs();
        #2;
        checks++; if (dev_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL devrd_rvalid: got %b expected 1", dev_rvalid); end
        checks++; if (mem_en !== 1'b0 || dev_gnt !== 1'b0) begin failures++; $display("[TB] FAIL devrd_wait_mem: got en=%b gnt=%b expected 0 0", mem_en, dev_gnt); end
        if (dev_q.size() == 0) begin
            checks++; failures++; $display("[TB] FAIL devrd_sb: got empty queue expected entry");
        end else begin
            exp = dev_q.pop_front();
            checks++; if (dev_rdata !== exp) begin failures++; $display("[TB] FAIL devrd_data: got %h expected %h", dev_rdata, exp); end
        end
        cycle();
        #2;
        checks++; if (dev_rvalid !== 1'b0 || dev_rdata !== 8'h00) begin failures++; $display("[TB] FAIL devrd_after: got rvalid=%b rdata=%h expected 0 00", dev_rvalid, dev_rdata); end
        cycle();
    endtask

    task automatic test_starvation();
        int  wins;
        bit  granted;
        logic [ADDR_W-1:0] held_addr;
        idle_inputs();
        cycle();
        // Phase 1: device waits from a cleared counter.
        dev_req = 1'b1; dev_we = 1'b1; dev_addr = 8'h30; dev_wdata = 8'h44;
        cpu_write = 1'b1;
        wins = 0; granted = 1'b0; held_addr = '0;
        for (int i = 0; i < 12 && !granted; i++) begin
            cpu_addr  = ADDR_W'(8'h40 + i);
            cpu_wdata = DATA_W'(8'h80 + i);
            held_addr = cpu_addr;
            #2;
            if (dev_gnt) begin
                granted = 1'b1;
                checks++; if (cpu_stall !== 1'b1) begin failures++; $display("[TB] FAIL starve_gnt_stall: got %b expected 1", cpu_stall); end
                checks++; if (mem_addr !== 8'h30 || mem_wdata !== 8'h44 || mem_we !== 1'b1) begin failures++; $display("[TB] FAIL starve_gnt_mem: got addr=%h wdata=%h we=%b expected 30 44 1", mem_addr, mem_wdata, mem_we); end
            end else begin
                wins++;
                checks++; if (cpu_stall !== 1'b0 || mem_addr !== cpu_addr) begin failures++; $display("[TB] FAIL starve_cpu_win: got stall=%b addr=%h expected 0 %h", cpu_stall, mem_addr, cpu_addr); end
            end
            cycle();
        end
        checks++; if (!granted) begin failures++; $display("[TB] FAIL starve_timeout: got no grant expected grant within 12 cycles"); end
        checks++; if (wins != STARVE_MAX) begin failures++; $display("[TB] FAIL starve_wins: got %0d expected %0d", wins, STARVE_MAX); end
        dev_req = 1'b0;
        #2;
        checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== held_addr) begin failures++; $display("[TB] FAIL starve_resume: got stall=%b we=%b addr=%h expected 0 1 %h", cpu_stall, mem_we, mem_addr, held_addr); end
        cycle();
        // Phase 2: two CPU wins, device drops for a cycle, counter must restart.
        dev_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cpu_addr = ADDR_W'(8'h50 + i);
            #2;
            checks++; if (dev_gnt !== 1'b0) begin failures++; $display("[TB] FAIL starve_pre_gnt: got %b expected 0", dev_gnt); end
            cycle();
        end
        dev_req = 1'b0;
        cycle();
        dev_req = 1'b1;
        wins = 0; granted = 1'b0;
        for (int i = 0; i < 12 && !granted; i++) begin
            cpu_addr = ADDR_W'(8'h60 + i);
            #2;
            if (dev_gnt) granted = 1'b1;
            else         wins++;
            cycle();
        end
        checks++; if (!granted) begin failures++; $display("[TB] FAIL starve_clr_timeout: got no grant expected grant within 12 cycles"); end
        checks++; if (wins != STARVE_MAX) begin failures++; $display("[TB] FAIL starve_clr_wins: got %0d expected %0d", wins, STARVE_MAX); end
        idle_inputs();
        cycle();
    endtask

    task automatic test_cpu_during_dev_read();
        logic [DATA_W-1:0] exp;
        idle_inputs();
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = 8'h20;
        #2;
        checks++; if (dev_gnt !== 1'b1) begin failures++; $display("[TB] FAIL cdr_gnt: got %b expected 1", dev_gnt); end
        dev_q.push_back(8'h33);
        cycle();
        dev_req = 1'b0;
        cpu_read = 1'b1; cpu_addr = 8'h10;
        #2;
        checks++; if (cpu_stall !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("[TB] FAIL cdr_blocked: got stall=%b en=%b expected 1 0", cpu_stall, mem_en); end
        if (dev_q.size() == 0) begin
            checks++; failures++; $display("[TB] FAIL cdr_dev_sb: got empty queue expected entry");
        end else begin
            exp = dev_q.pop_front();
            checks++; if (dev_rvalid !== 1'b1 || dev_rdata !== exp) begin failures++; $display("[TB] FAIL cdr_dev_data: got rvalid=%b rdata=%h expected 1 %h", dev_rvalid, dev_rdata, exp); end
        end
        cycle();
        #2;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10 || cpu_stall !== 1'b1) begin failures++; $display("[TB] FAIL cdr_cpu_issue: got en=%b we=%b addr=%h stall=%b expected 1 0 10 1", mem_en, mem_we, mem_addr, cpu_stall); end
        cpu_q.push_back(8'h5A);
        cycle();
        #2;
        if (cpu_q.size() == 0) begin
            checks++; failures++; $display("[TB] FAIL cdr_cpu_sb: got empty queue expected entry");
        end else begin
            exp = cpu_q.pop_front();
            checks++; if (cpu_rdata !== exp || cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL cdr_cpu_data: got rdata=%h stall=%b expected %h 0", cpu_rdata, cpu_stall, exp); end
        end
        cycle();
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        cpu_read = 1'b1; cpu_addr = 8'h10;
        #2;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("[TB] FAIL rw_cpu_issue: got %b expected 1", cpu_stall); end
        cycle();
        cpu_read = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 8'h00 || mem_en !== 1'b0) begin failures++; $display("[TB] FAIL rw_cpu_async: got stall=%b rdata=%h en=%b expected 0 00 0", cpu_stall, cpu_rdata, mem_en); end
        cycle();
        reset = 1'b0;
        #2;
        checks++; if (cpu_rdata !== 8'h00 || cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL rw_cpu_after: got rdata=%h stall=%b expected 00 0", cpu_rdata, cpu_stall); end
        cycle();
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = 8'h20;
        #2;
        checks++; if (dev_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rw_dev_gnt: got %b expected 1", dev_gnt); end
        cycle();
        dev_req = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (dev_rvalid !== 1'b0 || dev_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rw_dev_async: got rvalid=%b rdata=%h expected 0 00", dev_rvalid, dev_rdata); end
        cycle();
        reset = 1'b0;
        #2;
        checks++; if (dev_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rw_dev_after: got %b expected 0", dev_rvalid); end
        cycle();
    endtask

    task automatic test_read_write_both();
        logic [DATA_W-1:0] exp;
        idle_inputs();
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h05; cpu_wdata = 8'h7F;
        #2;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || cpu_stall !== 1'b0 || mem_wdata !== 8'h7F) begin failures++; $display("[TB] FAIL both_as_write: got en=%b we=%b stall=%b wdata=%h expected 1 1 0 7f", mem_en, mem_we, cpu_stall, mem_wdata); end
        cycle();
        cpu_write = 1'b0;
        #2;
        checks++; if (cpu_stall !== 1'b1) begin failures++; $display("[TB] FAIL both_rd_stall: got %b expected 1", cpu_stall); end
        cpu_q.push_back(8'h7F);
        cycle();
        #2;
        if (cpu_q.size() == 0) begin
            checks++; failures++; $display("[TB] FAIL both_sb: got empty queue expected entry");
        end else begin
            exp = cpu_q.pop_front();
            checks++; if (cpu_rdata !== exp) begin failures++; $display("[TB] FAIL both_rd_data: got %h expected %h", cpu_rdata, exp); end
        end
        cycle();
        idle_inputs();
        cycle();
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_dev_write_read();
        test_starvation();
        test_cpu_during_dev_read();
        test_reset_in_wait();
        test_read_write_both();
        checks++;
        if (cpu_q.size() != 0 || dev_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_leftover: got cpu=%0d dev=%0d expected 0 0", cpu_q.size(), dev_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
